// File: rtl/sym_sched_pkg.sv
// rtl/sym_sched_pkg.sv - shared types and constants for the OFDM symbol scheduler
package sym_sched_pkg;

    // Samples per OFDM symbol, shared with the IFFT modulator
    localparam int N_FFT_DEF = 256;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER_P,
        ST_XFER_D,
        ST_PAD
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_P    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/sym_sched_if.sv
// rtl/sym_sched_if.sv - preamble, data and downstream bus bundle of the symbol scheduler
interface sym_sched_if;

    // preamble source
    logic [31:0] p_dat;
    logic        p_cyc;
    logic        p_stb;
    logic        p_we;
    logic        p_ack;

    // data-symbol source
    logic [31:0] d_dat;
    logic        d_cyc;
    logic        d_stb;
    logic        d_we;
    logic        d_ack;

    // downstream to the IFFT modulator
    logic [31:0] dat;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;

    // scheduler view: slave to both sources, master towards the modulator
    modport master (
        input  p_dat, p_cyc, p_stb, p_we,
        output p_ack,
        input  d_dat, d_cyc, d_stb, d_we,
        output d_ack,
        output dat, cyc, stb, we,
        input  ack
    );

    // environment view: the two sources and the modulator
    modport slave (
        output p_dat, p_cyc, p_stb, p_we,
        input  p_ack,
        output d_dat, d_cyc, d_stb, d_we,
        input  d_ack,
        input  dat, cyc, stb, we,
        output ack
    );

endinterface

// File: rtl/sym_sched_cnt.sv
// rtl/sym_sched_cnt.sv - enabled modulo-N sample counter with terminal-count flag
module sym_cnt #(
    parameter int N = 256,
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    // count accepted samples, wrapping at the end of the symbol
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/sym_sched.sv
// rtl/sym_sched.sv - symbol-granular arbiter between preamble and data sources with zero padding
module sym_sched
    import sym_sched_pkg::*;
#(
    parameter int N_FFT = N_FFT_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    sym_sched_if.master      bus,
    output logic [1:0]       o_gnt,
    output logic [CNT_W-1:0] o_smp_cnt,
    output logic             o_sym_done,
    output logic             o_pad_err
);

    state_t      r_state;
    logic        r_cyc;
    logic [1:0]  r_gnt;
    logic        r_sym_done;
    logic        r_pad_err;

    logic [31:0]      w_dat;
    logic             w_stb;
    logic             w_p_ack;
    logic             w_d_ack;
    logic             w_accept;
    logic             w_tc;
    logic             w_src_cyc;
    logic [CNT_W-1:0] w_cnt;

    // Route the granted source straight through; a source that has dropped
    // cyc is not allowed to strobe, so a departing source never lands a sample.
    always_comb begin
        w_dat   = '0;
        w_stb   = 1'b0;
        w_p_ack = 1'b0;
        w_d_ack = 1'b0;
        case (r_state)
            ST_XFER_P: begin
                w_dat   = bus.p_dat;
                w_stb   = bus.p_cyc & bus.p_stb & bus.p_we;
                w_p_ack = w_stb & bus.ack;
            end
            ST_XFER_D: begin
                w_dat   = bus.d_dat;
                w_stb   = bus.d_cyc & bus.d_stb & bus.d_we;
                w_d_ack = w_stb & bus.ack;
            end
            ST_PAD: begin
                w_stb = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_accept  = w_stb & bus.ack;
    assign w_src_cyc = (r_state == ST_XFER_P) ? bus.p_cyc : bus.d_cyc;

    sym_cnt #(
        .N (N_FFT),
        .W (CNT_W)
    ) u_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_accept),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // Arbitration, transfer and padding control; status outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cyc      <= 1'b0;
            r_gnt      <= GNT_NONE;
            r_sym_done <= 1'b0;
            r_pad_err  <= 1'b0;
        end else begin
            r_sym_done <= 1'b0;
            r_pad_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.p_cyc || bus.d_cyc) begin
                        r_state <= ST_ARB;
                        r_cyc   <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (bus.p_cyc) begin
                        r_state <= ST_XFER_P;
                        r_gnt   <= GNT_P;
                    end else if (bus.d_cyc) begin
                        r_state <= ST_XFER_D;
                        r_gnt   <= GNT_D;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cyc   <= 1'b0;
                        r_gnt   <= GNT_NONE;
                    end
                end
                ST_XFER_P, ST_XFER_D, ST_PAD: begin
                    if (w_accept && w_tc) begin
                        r_state    <= ST_ARB;
                        r_sym_done <= 1'b1;
                    end else if (r_state != ST_PAD && !w_src_cyc) begin
                        // a source leaving mid-symbol is replaced by zeros so
                        // the modulator always sees whole symbols
                        if (w_cnt != '0) begin
                            r_state   <= ST_PAD;
                            r_pad_err <= 1'b1;
                        end else begin
                            r_state <= ST_ARB;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dat   = w_dat;
    assign bus.stb   = w_stb;
    assign bus.we    = w_stb;
    assign bus.cyc   = r_cyc;
    assign bus.p_ack = w_p_ack;
    assign bus.d_ack = w_d_ack;

    assign o_gnt      = r_gnt;
    assign o_smp_cnt  = w_cnt;
    assign o_sym_done = r_sym_done;
    assign o_pad_err  = r_pad_err;

endmodule

// File: tb/tb_sym_sched.sv
// tb/tb_sym_sched.sv - self-checking bench for sym_sched
module tb_sym_sched;
    import sym_sched_pkg::*;

    localparam int N = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sym_sched_if bus();

    logic [1:0] gnt;
    logic [7:0] smp_cnt;
    logic       sym_done;
    logic       pad_err;

    sym_sched #(.N_FFT(N), .CNT_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_gnt      (gnt),
        .o_smp_cnt  (smp_cnt),
        .o_sym_done (sym_done),
        .o_pad_err  (pad_err)
    );

    typedef struct {
        int         p_len;
        int         d_len;
        int         p_at;
        int         rnd;
        int         do_rst;
        int         exp_words;
        int         exp_pad;
        int         exp_done;
        int         exp_perr;
        logic [1:0] exp_gnt_last;
        int         exp_gap;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] p_words[$];
    logic [31:0] d_words[$];
    logic [31:0] out_q[$];
    logic [31:0] exp_q[$];
    logic [1:0]  gnt_q[$];
    logic [1:0]  exp_g[$];
    int          acc_cyc[$];

    int p_len, d_len, p_idx, d_idx, p_at, ack_mode;
    bit p_en;
    int cyc_n, mcnt, pad_words, cnt_bad, done_bad, n_done, n_perr;
    bit exp_done_next, p_ack_seen, d_ack_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        if (!p_en && p_at > 0 && d_idx >= p_at) p_en = 1'b1;
        bus.p_cyc = p_en && (p_idx < p_len);
        bus.p_stb = bus.p_cyc;
        bus.p_we  = bus.p_cyc;
        bus.p_dat = (p_idx < p_len) ? p_words[p_idx] : 32'h0;
        bus.d_cyc = (d_idx < d_len);
        bus.d_stb = bus.d_cyc;
        bus.d_we  = bus.d_cyc;
        bus.d_dat = (d_idx < d_len) ? d_words[d_idx] : 32'h0;
        case (ack_mode)
            0:       bus.ack = 1'b1;
            1:       bus.ack = 1'($urandom_range(0, 1));
            default: bus.ack = 1'b0;
        endcase
    endtask

    // observe one cycle away from the clock edge and score it against the model
    task automatic monitor();
        cyc_n++;
        if (sym_done !== exp_done_next) done_bad++;
        exp_done_next = 1'b0;
        if (sym_done === 1'b1) n_done++;
        if (pad_err === 1'b1) n_perr++;
        if (bus.stb === 1'b1 && bus.ack === 1'b1) begin
            out_q.push_back(bus.dat);
            gnt_q.push_back(gnt);
            acc_cyc.push_back(cyc_n);
            if (smp_cnt !== 8'(mcnt)) cnt_bad++;
            if (bus.p_ack !== 1'b1 && bus.d_ack !== 1'b1) pad_words++;
            exp_done_next = (mcnt == N - 1);
            mcnt = (mcnt + 1) % N;
        end
        p_ack_seen = (bus.p_ack === 1'b1);
        d_ack_seen = (bus.d_ack === 1'b1);
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (p_ack_seen) p_idx++;
        if (d_ack_seen) d_idx++;
        drive();
    endtask

    task automatic init_src(input int pl, input int dl, input int pat, input int mode);
        p_words.delete();
        d_words.delete();
        for (int i = 0; i < pl; i++) p_words.push_back($urandom);
        for (int i = 0; i < dl; i++) d_words.push_back($urandom);
        p_len = pl; d_len = dl; p_idx = 0; d_idx = 0;
        p_at = pat; p_en = (pat == 0); ack_mode = mode;
    endtask

    task automatic apply_reset();
        init_src(0, 0, 0, 0);
        rst = 1'b1;
        drive();
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    // a source's symbols are its words, zero-filled up to a whole symbol
    task automatic add_src(input logic [31:0] w[$], input int len, input logic [1:0] g);
        int pad;
        pad = (len % N == 0) ? 0 : N - (len % N);
        for (int i = 0; i < len; i++) begin exp_q.push_back(w[i]); exp_g.push_back(g); end
        for (int i = 0; i < pad; i++) begin exp_q.push_back(32'h0); exp_g.push_back(g); end
    endtask

    task automatic run_case(input string tag, input vec_t v);
        int settle;
        int nmis;
        if (v.do_rst != 0) apply_reset();
        init_src(v.p_len, v.d_len, v.p_at, (v.rnd != 0) ? 1 : 0);
        out_q.delete(); gnt_q.delete(); acc_cyc.delete();
        exp_q.delete(); exp_g.delete();
        mcnt = 0; pad_words = 0; cnt_bad = 0; done_bad = 0; n_done = 0; n_perr = 0;
        exp_done_next = 1'b0;
        if (v.p_at == 0 && v.p_len > 0) begin
            add_src(p_words, v.p_len, GNT_P);
            add_src(d_words, v.d_len, GNT_D);
        end else begin
            add_src(d_words, v.d_len, GNT_D);
            add_src(p_words, v.p_len, GNT_P);
        end
        drive();
        settle = 0;
        for (int b = 0; b < 4000; b++) begin
            cycle();
            if (out_q.size() >= v.exp_words) begin
                settle++;
                if (settle == 4) break;
            end
        end
        chk({tag, "_timeout"}, 32'(settle < 4), 32'(0));
        init_src(0, 0, 0, 0);
        drive();
        nmis = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= out_q.size()) nmis++;
            else if (out_q[i] !== exp_q[i] || gnt_q[i] !== exp_g[i]) nmis++;
        end
        chk({tag, "_seq_mismatches"}, 32'(nmis), 32'(0));
        chk({tag, "_model_len"}, 32'(exp_q.size()), 32'(v.exp_words));
        chk({tag, "_words"}, 32'(out_q.size()), 32'(v.exp_words));
        chk({tag, "_pad_words"}, 32'(pad_words), 32'(v.exp_pad));
        chk({tag, "_sym_done"}, 32'(n_done), 32'(v.exp_done));
        chk({tag, "_pad_err"}, 32'(n_perr), 32'(v.exp_perr));
        chk({tag, "_cnt_skips"}, 32'(cnt_bad), 32'(0));
        chk({tag, "_done_timing"}, 32'(done_bad), 32'(0));
        chk({tag, "_gnt_last"}, (gnt_q.size() > 0) ? 32'(gnt_q[gnt_q.size() - 1]) : 32'hffff_ffff,
            32'(v.exp_gnt_last));
        if (v.exp_gap != 0) begin
            chk({tag, "_arb_gap"}, (acc_cyc.size() > N) ? 32'(acc_cyc[N] - acc_cyc[N - 1]) : 32'hffff_ffff,
                32'(v.exp_gap));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   got;

        tbl[0] = '{p_len:0,   d_len:256, p_at:0, rnd:0, do_rst:1, exp_words:256, exp_pad:0,   exp_done:1, exp_perr:0, exp_gnt_last:GNT_D, exp_gap:0};
        tbl[1] = '{p_len:256, d_len:256, p_at:0, rnd:0, do_rst:1, exp_words:512, exp_pad:0,   exp_done:2, exp_perr:0, exp_gnt_last:GNT_D, exp_gap:2};
        tbl[2] = '{p_len:0,   d_len:100, p_at:0, rnd:0, do_rst:1, exp_words:256, exp_pad:156, exp_done:1, exp_perr:1, exp_gnt_last:GNT_D, exp_gap:0};
        tbl[3] = '{p_len:0,   d_len:256, p_at:0, rnd:1, do_rst:1, exp_words:256, exp_pad:0,   exp_done:1, exp_perr:0, exp_gnt_last:GNT_D, exp_gap:0};
        tbl[4] = '{p_len:256, d_len:0,   p_at:0, rnd:1, do_rst:1, exp_words:256, exp_pad:0,   exp_done:1, exp_perr:0, exp_gnt_last:GNT_P, exp_gap:0};
        tbl[5] = '{p_len:50,  d_len:256, p_at:0, rnd:1, do_rst:1, exp_words:512, exp_pad:206, exp_done:2, exp_perr:1, exp_gnt_last:GNT_D, exp_gap:0};

        cyc_n = 0;
        apply_reset();

        // reset state with strobes and ack high but no cyc
        bus.p_stb = 1'b1; bus.p_we = 1'b1; bus.d_stb = 1'b1; bus.d_we = 1'b1; bus.ack = 1'b1;
        #1;
        chk("rst_cyc", 32'(bus.cyc), 32'(0));
        chk("rst_stb", 32'(bus.stb), 32'(0));
        chk("rst_we", 32'(bus.we), 32'(0));
        chk("rst_dat", bus.dat, 32'h0);
        chk("rst_p_ack", 32'(bus.p_ack), 32'(0));
        chk("rst_d_ack", 32'(bus.d_ack), 32'(0));
        chk("rst_gnt", 32'(gnt), 32'(GNT_NONE));
        chk("rst_cnt", 32'(smp_cnt), 32'(0));
        chk("rst_done", 32'(sym_done), 32'(0));
        chk("rst_pad_err", 32'(pad_err), 32'(0));
        drive();

        for (int r = 0; r < 6; r++) run_case($sformatf("case%0d", r), tbl[r]);

        // P raises cyc at D sample 10: D symbol finishes before P is granted
        v = '{p_len:256, d_len:256, p_at:10, rnd:0, do_rst:1, exp_words:512, exp_pad:0, exp_done:2, exp_perr:0, exp_gnt_last:GNT_P, exp_gap:2};
        run_case("p_mid_d", v);

        // ack held low while strobing: nothing advances
        apply_reset();
        init_src(0, 256, 0, 2);
        drive();
        repeat (5) cycle();
        #1;
        chk("hold_stb", 32'(bus.stb), 32'(1));
        chk("hold_dat0", bus.dat, d_words[0]);
        chk("hold_cnt0", 32'(smp_cnt), 32'(0));
        chk("hold_d_ack", 32'(bus.d_ack), 32'(0));
        chk("hold_gnt", 32'(gnt), 32'(GNT_D));
        bus.ack = 1'b1;
        cycle();
        #1;
        chk("hold_cnt1", 32'(smp_cnt), 32'(1));
        chk("hold_dat1", bus.dat, d_words[1]);
        repeat (3) cycle();
        #1;
        chk("hold_cnt1_kept", 32'(smp_cnt), 32'(1));
        chk("hold_dat1_kept", bus.dat, d_words[1]);

        // reset in the middle of a symbol, then a clean symbol
        apply_reset();
        init_src(0, 256, 0, 0);
        out_q.delete();
        drive();
        for (int b = 0; b < 1000; b++) begin
            cycle();
            if (out_q.size() >= 128) break;
        end
        got = out_q.size();
        chk("rst_mid_reached", 32'(got), 32'(128));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        init_src(0, 0, 0, 0);
        drive();
        #1;
        chk("rst_mid_cyc", 32'(bus.cyc), 32'(0));
        chk("rst_mid_stb", 32'(bus.stb), 32'(0));
        chk("rst_mid_cnt", 32'(smp_cnt), 32'(0));
        chk("rst_mid_gnt", 32'(gnt), 32'(GNT_NONE));
        chk("rst_mid_pad_err", 32'(pad_err), 32'(0));
        chk("rst_mid_dat", bus.dat, 32'h0);
        v = '{p_len:0, d_len:256, p_at:0, rnd:0, do_rst:0, exp_words:256, exp_pad:0, exp_done:1, exp_perr:0, exp_gnt_last:GNT_D, exp_gap:0};
        run_case("after_rst", v);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sym_sched.md
SYM_SCHED -- requirements
Module: sym_sched

Interface
REQ-001 The block SHALL have parameter N_FFT, default 256, meaning samples per OFDM symbol (power of two, 64..1024).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning sample-counter width, equal to log2(N_FFT).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
- CLK_I  in  1  sole clock; all logic on its rising edge.
- RST_I  in  1  synchronous reset, active high.
REQ-004 Preamble source port (P, slave side) SHALL be:
- P_DAT_I in 32 (Im[31:16], Re[15:0], 1.15); P_CYC_I, P_STB_I, P_WE_I in 1; P_ACK_O out 1.
REQ-005 Data-symbol source port (D, slave side) SHALL be:
- D_DAT_I in 32; D_CYC_I, D_STB_I, D_WE_I in 1; D_ACK_O out 1.
REQ-006 Downstream port to the IFFT modulator (master side) SHALL be:
- DAT_O out 32; CYC_O, STB_O, WE_O out 1; ACK_I in 1.
REQ-007 Status outputs SHALL be:
- GNT_O out 2 (01=P, 10=D, 00=none); SMP_CNT_O out CNT_W; SYM_DONE_O out 1 (pulse); PAD_ERR_O out 1 (pulse).

Function
REQ-008 States SHALL be IDLE, ARB, XFER_P, XFER_D, PAD.
REQ-009 IDLE: CYC_O=0; go to ARB when P_CYC_I or D_CYC_I is high.
REQ-010 ARB (1 cycle): CYC_O=1; if P_CYC_I go XFER_P, else if D_CYC_I go XFER_D, else go IDLE. P has fixed priority.
REQ-011 XFER_x SHALL route the granted port combinationally: DAT_O=x_DAT_I, STB_O=x_STB_I&x_WE_I, WE_O=STB_O, x_ACK_O=STB_O&ACK_I.
REQ-012 The non-granted ACK_O SHALL be 0 at all times.
REQ-013 A sample is accepted when STB_O&ACK_I; SMP_CNT_O SHALL increment per acceptance and wrap from N_FFT-1 to 0.
REQ-014 On acceptance at count N_FFT-1, SYM_DONE_O SHALL pulse one cycle and the state SHALL return to ARB; the grant therefore changes only at symbol boundaries.
REQ-015 If the granted x_CYC_I falls while SMP_CNT_O≠0 in XFER_x, the block SHALL enter PAD, pulse PAD_ERR_O once, and detach the source (x_ACK_O=0).
REQ-016 PAD: STB_O=WE_O=1, DAT_O=32'd0 until the symbol completes; completion follows REQ-014.
REQ-017 If x_CYC_I falls while SMP_CNT_O=0 (clean boundary), the block SHALL go to ARB without padding and without PAD_ERR_O.
REQ-018 CYC_O SHALL be 1 in ARB, XFER_P, XFER_D and PAD, and 0 in IDLE.
REQ-019 ACK_I low with STB_O high SHALL hold DAT_O, STB_O, SMP_CNT_O and the state unchanged (no sample lost or duplicated).
REQ-020 If P_CYC_I rises mid-symbol during XFER_D, the block SHALL finish the D symbol first, then grant P at ARB.
REQ-021 GNT_O SHALL be 01 in XFER_P, 10 in XFER_D, and hold the last grant during PAD.
REQ-022 Combinational latency from x_STB_I to STB_O and from ACK_I to x_ACK_O SHALL be 0 cycles; ARB costs 1 cycle per symbol.

Reset
REQ-023 On RST_I the block SHALL enter IDLE with SMP_CNT_O=0, GNT_O=00, CYC_O=STB_O=WE_O=0, DAT_O=0, all ACK_O=0, SYM_DONE_O=PAD_ERR_O=0.
REQ-024 RST_I asserted mid-symbol SHALL abort the symbol without padding; the following cycle SHALL present the reset values.

Structure
REQ-025 A shared package SHALL hold the state enumeration, the GNT encodings and the N_FFT default shared with the IFFT modulator.
REQ-026 One sub-module, sym_cnt (an enabled modulo-N_FFT counter with terminal-count output), is natural; the FSM and mux stay in sym_sched.

Verification (N_FFT=256 unless noted)
REQ-027 D-only stream, ACK_I tied 1: 256 samples pass unchanged, then SYM_DONE_O pulses once, GNT_O=10, and 0 samples are padded.
REQ-028 P and D both raise CYC in the same cycle: the 256 P samples go out first, then the 256 D samples; exactly one ARB cycle separates the two symbols.
REQ-029 D drops CYC after 100 samples: PAD_ERR_O pulses once and 156 zero words follow, then SYM_DONE_O pulses.
REQ-030 ACK_I toggled with a random 50% duty: the output sequence equals the input sequence exactly, and SMP_CNT_O never skips a value.
REQ-031 P_CYC_I rises at D sample 10: the D symbol completes all 256 samples, then GNT_O becomes 01.
REQ-032 RST_I pulsed at sample 128: the next cycle shows IDLE outputs with CYC_O=0, and a fresh symbol afterwards transfers 256 samples normally.
